imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single synchronous port of the instruction memory between two requesters:
//   - the core fetch stage;
//   - the program loader (debug/boot writer).
//  A BOOT/RUN mode FSM keeps fetch off the port until the loader has finished.
//  In RUN mode, a fixed-priority arbiter grants the loader first; a starvation counter protects fetch.
//  Read data returns one cycle after grant and is routed back to its owner by a registered tag.
// PARAMETERS
//  ADDR_W      32  byte-address width on all ports
//  DATA_W      32  instruction/data word width
//  STARVE_MAX  8   consecutive RUN-mode loader grants with fetch pending before fetch is forced
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  i_boot_done  in   1       loader pulse: program load finished, enter RUN
//  i_boot_req   in   1       pulse: return to BOOT (reload program)
//  o_run        out  1       1 = RUN mode, 0 = BOOT mode
//  i_f_req      in   1       fetch read request
//  i_f_addr     in   ADDR_W  fetch byte address
//  o_f_gnt      out  1       fetch request accepted this cycle (combinational)
//  o_f_rvalid   out  1       fetch read data valid
//  o_f_rdata    out  DATA_W  fetch read data
//  i_l_req      in   1       loader request
//  i_l_we       in   1       loader write enable (1 = write, 0 = read)
//  i_l_addr     in   ADDR_W  loader byte address
//  i_l_wdata    in   DATA_W  loader write data
//  o_l_gnt      out  1       loader request accepted this cycle (combinational)
//  o_l_rvalid   out  1       loader read data valid
//  o_l_rdata    out  DATA_W  loader read data
//  o_mem_en     out  1       memory access enable
//  o_mem_we     out  1       memory write enable
//  o_mem_addr   out  ADDR_W  memory byte address, bits [1:0] forced to 0
//  o_mem_wdata  out  DATA_W  memory write data
//  i_mem_rdata  in   DATA_W  memory read data, valid 1 cycle after an enabled read
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - mode=BOOT, starve_cnt=0, resp tag=NONE;
//   - every output 0, including combinational gnt/mem outputs while rst_n is low.
//  Mode FSM:
//   - BOOT -> RUN on i_boot_done; RUN -> BOOT on i_boot_req.
//   - Both pulses in the same cycle: i_boot_req wins (stay in/enter BOOT).
//  BOOT mode: only the loader is granted; o_f_gnt=0 and starve_cnt is held at 0.
//  RUN mode grant rule (at most one grant per cycle):
//   - fetch is granted if i_f_req && (!i_l_req || starve_cnt==STARVE_MAX);
//   - otherwise the loader is granted if i_l_req.
//  starve_cnt (RUN mode only):
//   - +1 on a loader grant while i_f_req=1;
//   - clears on a fetch grant or when i_f_req=0;
//   - saturates at STARVE_MAX.
//  Memory command (same cycle as grant):
//   - o_mem_en=1 on any grant;
//   - o_mem_we=i_l_we & o_l_gnt (fetch never writes);
//   - addr/wdata muxed from the granted requester; wdata=0 on fetch grants.
//  Response:
//   - the tag register captures F, L, or NONE (NONE for writes or no grant).
//   - Next cycle, the tag selects which rvalid=1, and that rdata=i_mem_rdata.
//   - The non-selected rdata is 0.
//  Throughput: back-to-back grants every cycle; one response in flight per cycle, fully pipelined.
//  Requesters hold req/addr/data stable until gnt; no request is dropped or queued internally.
//  Reset asserted with a response pending: response discarded, rvalid stays 0 after release.
//  Mode change with a read in flight: the read still completes to its tagged owner next cycle.
//  Misaligned addresses: low 2 bits ignored, no error.
// TESTING
//  1. Reset, i_f_req=1 in BOOT -> o_f_gnt=0 for all cycles; o_run=0.
//  2. BOOT, loader writes 0x00000013 @0x0, then reads @0x0 -> o_l_rvalid=1, o_l_rdata=0x00000013 one cycle after gnt.
//  3. Pulse i_boot_done, fetch reads @0x0, 0x4, 0x8 back-to-back -> 3 consecutive gnts; rvalid in cycles 2-4 with the stored words.
//  4. RUN, i_l_req and i_f_req both held high -> loader granted 8 times, fetch granted on the 9th, then count restarts.
//  5. i_boot_done and i_boot_req pulsed together in BOOT -> stays BOOT; a single i_boot_req in RUN -> BOOT next cycle.
//  6. rst_n dropped the cycle after a fetch grant -> all outputs 0 immediately; no o_f_rvalid after release.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares the instruction memory's single synchronous port between the fetch stage and the program loader.
// A BOOT/RUN mode FSM gates fetch. A starvation counter bounds how long the loader can hold fetch off.
module imem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_boot_done,
    input  logic              i_boot_req,
    output logic              o_run,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    output logic              o_l_gnt,
    output logic              o_l_rvalid,
    output logic [DATA_W-1:0] o_l_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic {MODE_BOOT = 1'b0, MODE_RUN = 1'b1} mode_e;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_F = 2'd1, TAG_L = 2'd2} tag_e;

    mode_e            mode_q, mode_d;
    tag_e             tag_q, tag_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             f_gnt_s, l_gnt_s;
    logic [ADDR_W-1:0] addr_sel_s;

    // Grant decision and memory command; everything is forced low while reset is asserted
    always_comb begin
        f_gnt_s     = 1'b0;
        l_gnt_s     = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        addr_sel_s  = {ADDR_W{1'b0}};
        o_mem_wdata = {DATA_W{1'b0}};
        if (rst_n) begin
            if (mode_q == MODE_RUN && i_f_req && (!i_l_req || starve_q == STARVE_LIM)) begin
                f_gnt_s = 1'b1;
            end else if (i_l_req) begin
                l_gnt_s = 1'b1;
            end else begin
                f_gnt_s = 1'b0;
                l_gnt_s = 1'b0;
            end
        end else begin
            f_gnt_s = 1'b0;
            l_gnt_s = 1'b0;
        end
        if (f_gnt_s) begin
            o_mem_en   = 1'b1;
            addr_sel_s = i_f_addr;
        end else if (l_gnt_s) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_l_we;
            addr_sel_s  = i_l_addr;
            o_mem_wdata = i_l_wdata;
        end else begin
            o_mem_en = 1'b0;
        end
        o_mem_addr = addr_sel_s & WORD_MASK;
        o_f_gnt    = f_gnt_s;
        o_l_gnt    = l_gnt_s;
    end

    // Next mode, starvation count and response tag
    always_comb begin
        mode_d   = mode_q;
        starve_d = starve_q;
        tag_d    = TAG_NONE;
        // A reload request overrides a simultaneous load-finished pulse
        case (mode_q)
            MODE_BOOT: begin
                if (i_boot_req) begin
                    mode_d = MODE_BOOT;
                end else if (i_boot_done) begin
                    mode_d = MODE_RUN;
                end else begin
                    mode_d = MODE_BOOT;
                end
            end
            MODE_RUN: begin
                if (i_boot_req) begin
                    mode_d = MODE_BOOT;
                end else begin
                    mode_d = MODE_RUN;
                end
            end
            default: mode_d = MODE_BOOT;
        endcase
        if (mode_q != MODE_RUN || f_gnt_s || !i_f_req) begin
            starve_d = {CNT_W{1'b0}};
        end else if (l_gnt_s && starve_q != STARVE_LIM) begin
            starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_d = starve_q;
        end
        if (f_gnt_s) begin
            tag_d = TAG_F;
        end else if (l_gnt_s && !i_l_we) begin
            tag_d = TAG_L;
        end else begin
            tag_d = TAG_NONE;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_BOOT;
            starve_q <= {CNT_W{1'b0}};
            tag_q    <= TAG_NONE;
        end else begin
            mode_q   <= mode_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    // Route the returning read word to the owner captured in the tag
    always_comb begin
        o_run      = (mode_q == MODE_RUN);
        o_f_rvalid = (tag_q == TAG_F);
        o_l_rvalid = (tag_q == TAG_L);
        o_f_rdata  = o_f_rvalid ? i_mem_rdata : {DATA_W{1'b0}};
        o_l_rdata  = o_l_rvalid ? i_mem_rdata : {DATA_W{1'b0}};
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small synchronous memory model attached to the port.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_done, boot_req, o_run;
    logic        f_req, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_gnt, l_rvalid;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_boot_done(boot_done), .i_boot_req(boot_req), .o_run(o_run),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
        .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory model
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic idle();
        boot_done = 1'b0; boot_req = 1'b0;
        f_req = 1'b0; f_addr = 32'h0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        f_req = 1'b1;
        #2;
        total++;
        if ({o_run, f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we} !== 7'b0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {o_run, f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (f_gnt !== 1'b0 || o_run !== 1'b0 || mem_en !== 1'b0) begin
                bad++; $display("FAIL boot_no_fetch cyc=%0d gnt=%b run=%b en=%b exp=000", i, f_gnt, o_run, mem_en);
            end
        end
        @(posedge clk); #1 idle();
    endtask

    task automatic test_boot_loader();
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        wa[0] = 32'h0; wa[1] = 32'h4; wa[2] = 32'h8;
        wd[0] = 32'h0000_0013; wd[1] = 32'hA0A0_0004; wd[2] = 32'hB0B0_0008;
        l_req = 1'b1; l_we = 1'b1; l_addr = wa[0]; l_wdata = wd[0];
        @(negedge clk);
        total++;
        if (l_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h13) begin
            bad++; $display("FAIL loader_write gnt=%b en=%b we=%b addr=%h wd=%h exp 1 1 1 0 13", l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        l_we = 1'b0; l_addr = 32'h2; l_wdata = 32'h0;
        @(negedge clk);
        total++;
        if (l_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL loader_read_cmd gnt=%b we=%b addr=%h exp 1 0 0", l_gnt, mem_we, mem_addr);
        end
        @(posedge clk); #1 idle();
        @(negedge clk);
        total++;
        if (l_rvalid !== 1'b1 || l_rdata !== 32'h13 || f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin
            bad++; $display("FAIL loader_read_resp rv=%b rd=%h frv=%b frd=%h exp 1 13 0 0", l_rvalid, l_rdata, f_rvalid, f_rdata);
        end
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            l_req = 1'b1; l_we = 1'b1; l_addr = wa[i]; l_wdata = wd[i];
        end
        @(posedge clk); #1 idle();
        @(negedge clk);
        total++;
        if (l_rvalid !== 1'b0) begin
            bad++; $display("FAIL write_no_rvalid got=%b exp=0", l_rvalid);
        end
    endtask

    task automatic test_run_fetch();
        logic [31:0] exp [3];
        exp[0] = 32'h0000_0013; exp[1] = 32'hA0A0_0004; exp[2] = 32'hB0B0_0008;
        @(posedge clk); #1 boot_done = 1'b1;
        @(posedge clk); #1 boot_done = 1'b0;
        total++;
        if (o_run !== 1'b1) begin
            bad++; $display("FAIL enter_run got=%b exp=1", o_run);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin f_req = 1'b1; f_addr = 32'(i * 4); end
            else begin f_req = 1'b0; f_addr = 32'h0; end
            @(negedge clk);
            if (i < 3) begin
                total++;
                if (f_gnt !== 1'b1 || mem_addr !== 32'(i * 4) || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
                    bad++; $display("FAIL fetch_gnt i=%0d gnt=%b addr=%h we=%b wd=%h", i, f_gnt, mem_addr, mem_we, mem_wdata);
                end
            end
            if (i > 0) begin
                total++;
                if (f_rvalid !== 1'b1 || f_rdata !== exp[i-1] || l_rvalid !== 1'b0) begin
                    bad++; $display("FAIL fetch_resp i=%0d rv=%b rd=%h exp 1 %h", i, f_rvalid, f_rdata, exp[i-1]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_starve();
        logic ef;
        f_req = 1'b1; f_addr = 32'h4;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'hF0; l_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 18; i++) begin
            ef = (i == 8 || i == 17);
            @(negedge clk);
            total++;
            if (f_gnt !== ef || l_gnt !== !ef) begin
                bad++; $display("FAIL starve cyc=%0d fgnt=%b lgnt=%b exp %b %b", i, f_gnt, l_gnt, ef, !ef);
            end
            @(posedge clk); #1;
        end
        // Dropping fetch clears the count: 8 more loader grants before fetch wins again
        f_req = 1'b0;
        @(posedge clk); #1 f_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ef = (i == 8);
            @(negedge clk);
            total++;
            if (f_gnt !== ef) begin
                bad++; $display("FAIL starve_clear cyc=%0d fgnt=%b exp %b", i, f_gnt, ef);
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_mode();
        f_req = 1'b1; f_addr = 32'h4; boot_req = 1'b1;
        @(negedge clk);
        total++;
        if (f_gnt !== 1'b1) begin
            bad++; $display("FAIL gnt_before_boot got=%b exp=1", f_gnt);
        end
        @(posedge clk); #1 idle();
        total++;
        if (o_run !== 1'b0 || f_rvalid !== 1'b1 || f_rdata !== 32'hA0A0_0004) begin
            bad++; $display("FAIL run_to_boot run=%b rv=%b rd=%h exp 0 1 a0a00004", o_run, f_rvalid, f_rdata);
        end
        boot_done = 1'b1; boot_req = 1'b1; f_req = 1'b1;
        @(negedge clk);
        total++;
        if (f_gnt !== 1'b0) begin
            bad++; $display("FAIL boot_fetch_blocked got=%b exp=0", f_gnt);
        end
        @(posedge clk); #1 idle();
        total++;
        if (o_run !== 1'b0) begin
            bad++; $display("FAIL both_pulses got=%b exp=0", o_run);
        end
        boot_done = 1'b1;
        @(posedge clk); #1 boot_done = 1'b0;
        total++;
        if (o_run !== 1'b1) begin
            bad++; $display("FAIL reenter_run got=%b exp=1", o_run);
        end
    endtask

    task automatic test_reset_inflight();
        f_req = 1'b1; f_addr = 32'h8;
        @(negedge clk);
        total++;
        if (f_gnt !== 1'b1) begin
            bad++; $display("FAIL pre_reset_gnt got=%b exp=1", f_gnt);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        total++;
        if ({o_run, f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we} !== 7'b0 || f_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_inflight got=%b rd=%h exp=0", {o_run, f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we}, f_rdata);
        end
        f_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (f_rvalid !== 1'b0 || o_run !== 1'b0) begin
                bad++; $display("FAIL post_reset cyc=%0d rv=%b run=%b exp 0 0", i, f_rvalid, o_run);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_loader();
        test_run_fetch();
        test_starve();
        test_mode();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
